// File: rtl/regfile_sb_if.sv
// +----------------------------------------------------------------------------+
// | Module      : regfile_sb_if                                                |
// | Description : Bundle of the register file's write-back, read, reservation  |
// |               and flush signals. The master drives requests (decode and    |
// |               writeback); the slave is the register file itself.          |
// | Ports       : none (signal bundle only)                                    |
// |   i_wr_en/i_wr_addr/i_wr_data   writeback port                              |
// |   i_rd_addr1/2, o_rd_data1/2    combinational read ports                    |
// |   o_rd_busy1/2                  busy status of the addressed registers      |
// |   i_rsv_en/i_rsv_addr           destination reservation request             |
// |   o_rsv_stall                   reservation refused this cycle              |
// |   i_flush                       drop all reservations                       |
// |   o_busy_cnt                    number of reserved registers                |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

interface regfile_sb_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
);
  localparam int AW = $clog2(NREGS);

  logic            i_wr_en;
  logic [AW-1:0]   i_wr_addr;
  logic [XLEN-1:0] i_wr_data;
  logic [AW-1:0]   i_rd_addr1;
  logic [AW-1:0]   i_rd_addr2;
  logic [XLEN-1:0] o_rd_data1;
  logic [XLEN-1:0] o_rd_data2;
  logic            o_rd_busy1;
  logic            o_rd_busy2;
  logic            i_rsv_en;
  logic [AW-1:0]   i_rsv_addr;
  logic            o_rsv_stall;
  logic            i_flush;
  logic [AW:0]     o_busy_cnt;

  modport master (
    output i_wr_en, i_wr_addr, i_wr_data,
    output i_rd_addr1, i_rd_addr2,
    input  o_rd_data1, o_rd_data2, o_rd_busy1, o_rd_busy2,
    output i_rsv_en, i_rsv_addr,
    input  o_rsv_stall,
    output i_flush,
    input  o_busy_cnt
  );

  modport slave (
    input  i_wr_en, i_wr_addr, i_wr_data,
    input  i_rd_addr1, i_rd_addr2,
    output o_rd_data1, o_rd_data2, o_rd_busy1, o_rd_busy2,
    input  i_rsv_en, i_rsv_addr,
    output o_rsv_stall,
    input  i_flush,
    output o_busy_cnt
  );
endinterface

`default_nettype wire

// File: rtl/regfile_sb.sv
// +----------------------------------------------------------------------------+
// | Module      : regfile_sb                                                   |
// | Description : Two-read / one-write register file with a per-register busy  |
// |               scoreboard. Decode reserves destination registers, writeback |
// |               releases them; read ports report data and busy status.       |
// | Ports       : clk   - clock, rising edge                                   |
// |               rst_n - asynchronous active-low reset                        |
// |               bus   - regfile_sb_if.slave (write, read, reserve, flush,    |
// |                       busy count)                                          |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  wire logic    clk,
  input  wire logic    rst_n,
  regfile_sb_if.slave  bus
);

  localparam int AW = $clog2(NREGS);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_CNT_MAX = CW'(NREGS - ZERO_REG);
  localparam bit C_HAS_ZERO = (ZERO_REG != 0);
  localparam bit C_HAS_BYP  = (BYPASS != 0);

  logic [XLEN-1:0] r_mem [NREGS];
  logic [NREGS-1:0] r_busy;
  logic [CW-1:0]   r_busy_cnt;

  logic w_wr_ok;        // write that actually touches storage
  logic w_rsv_zero;     // reservation aimed at the hardwired zero register
  logic w_wr_hits_rsv;  // same-cycle writeback releases the requested register
  logic w_stall;
  logic w_rsv_ok;       // reservation that actually sets a busy bit
  logic w_inc;
  logic w_dec;

  assign w_wr_ok       = bus.i_wr_en && !(C_HAS_ZERO && (bus.i_wr_addr == '0));
  assign w_rsv_zero    = C_HAS_ZERO && (bus.i_rsv_addr == '0);
  assign w_wr_hits_rsv = bus.i_wr_en && (bus.i_wr_addr == bus.i_rsv_addr);

  // A busy destination can still be claimed when writeback frees it in the
  // same cycle; flush overrides everything, so it never stalls decode.
  assign w_stall  = bus.i_rsv_en && r_busy[bus.i_rsv_addr] && !w_wr_hits_rsv
                    && !bus.i_flush;
  assign w_rsv_ok = bus.i_rsv_en && !w_stall && !bus.i_flush && !w_rsv_zero;

  // Count tracks the number of set busy bits. A write+reserve to the same
  // busy register leaves it busy, so neither direction fires in that case.
  assign w_inc = w_rsv_ok && !r_busy[bus.i_rsv_addr];
  assign w_dec = w_wr_ok && r_busy[bus.i_wr_addr]
                 && !(w_rsv_ok && (bus.i_rsv_addr == bus.i_wr_addr));

  // Storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_mem[bus.i_wr_addr] <= bus.i_wr_data;
    end
  end

  // Busy bits: a reservation is applied after the release so that a
  // simultaneous write+reserve to one register leaves it owned again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else if (bus.i_flush) begin
      r_busy <= '0;
    end else begin
      if (w_wr_ok) begin
        r_busy[bus.i_wr_addr] <= 1'b0;
      end
      if (w_rsv_ok) begin
        r_busy[bus.i_rsv_addr] <= 1'b1;
      end
    end
  end

  // Busy counter (net change, saturating at both ends)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy_cnt <= '0;
    end else if (bus.i_flush) begin
      r_busy_cnt <= '0;
    end else if (w_inc && !w_dec && (r_busy_cnt != C_CNT_MAX)) begin
      r_busy_cnt <= r_busy_cnt + 1'b1;
    end else if (w_dec && !w_inc && (r_busy_cnt != '0)) begin
      r_busy_cnt <= r_busy_cnt - 1'b1;
    end
  end

  // Read ports
  logic w_rd1_zero, w_rd2_zero;
  logic w_byp1, w_byp2;

  assign w_rd1_zero = C_HAS_ZERO && (bus.i_rd_addr1 == '0);
  assign w_rd2_zero = C_HAS_ZERO && (bus.i_rd_addr2 == '0);
  // w_wr_ok already excludes the zero register, so it is never forwarded.
  assign w_byp1 = C_HAS_BYP && w_wr_ok && (bus.i_wr_addr == bus.i_rd_addr1);
  assign w_byp2 = C_HAS_BYP && w_wr_ok && (bus.i_wr_addr == bus.i_rd_addr2);

  // A forwarded value is always reported not-busy: any reservation accepted
  // this cycle only shows up from the next cycle on.
  assign bus.o_rd_data1 = w_rd1_zero ? '0 :
                          w_byp1     ? bus.i_wr_data : r_mem[bus.i_rd_addr1];
  assign bus.o_rd_data2 = w_rd2_zero ? '0 :
                          w_byp2     ? bus.i_wr_data : r_mem[bus.i_rd_addr2];
  assign bus.o_rd_busy1 = !w_rd1_zero && !w_byp1 && r_busy[bus.i_rd_addr1];
  assign bus.o_rd_busy2 = !w_rd2_zero && !w_byp2 && r_busy[bus.i_rd_addr2];

  assign bus.o_rsv_stall = w_stall;
  assign bus.o_busy_cnt  = r_busy_cnt;

endmodule

`default_nettype wire

// File: tb/tb_regfile_sb.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_regfile_sb                                                |
// | Description : Directed self-checking bench for regfile_sb. Three instances:|
// |               default (bypass on), bypass off, and a small 16x8 file       |
// |               without a zero register.                                     |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_regfile_sb;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_bad;

  regfile_sb_if #(.XLEN(32), .NREGS(32)) bus_a ();
  regfile_sb_if #(.XLEN(32), .NREGS(32)) bus_b ();
  regfile_sb_if #(.XLEN(16), .NREGS(8))  bus_c ();

  regfile_sb #(.XLEN(32), .NREGS(32), .ZERO_REG(1), .BYPASS(1)) u_byp (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );
  regfile_sb #(.XLEN(32), .NREGS(32), .ZERO_REG(1), .BYPASS(0)) u_nobyp (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );
  regfile_sb #(.XLEN(16), .NREGS(8), .ZERO_REG(0), .BYPASS(1)) u_small (
    .clk(clk), .rst_n(rst_n), .bus(bus_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Request strobes low; read addresses are left as they are.
  task automatic idle();
    bus_a.i_wr_en = 0; bus_a.i_rsv_en = 0; bus_a.i_flush = 0;
    bus_b.i_wr_en = 0; bus_b.i_rsv_en = 0; bus_b.i_flush = 0;
    bus_c.i_wr_en = 0; bus_c.i_rsv_en = 0; bus_c.i_flush = 0;
  endtask

  // Clock edge, then drop requests so checks see stored state.
  task automatic step();
    @(posedge clk);
    #1;
    idle();
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst_n = 0;
    #2;
    rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    bus_a.i_wr_en = 1; bus_a.i_wr_addr = 5; bus_a.i_wr_data = 32'hDEADBEEF;
    bus_a.i_rsv_en = 1; bus_a.i_rsv_addr = 5;
    step();
    bus_a.i_rd_addr1 = 5;
    #1;
    n_total++;
    if (bus_a.o_rd_data1 !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL reset_preload_data: got %h expected deadbeef", bus_a.o_rd_data1);
    end
    n_total++;
    if (bus_a.o_rd_busy1 !== 1'b1 || bus_a.o_busy_cnt !== 6'd1) begin
      n_bad++; $display("FAIL reset_preload_busy: busy=%b cnt=%0d expected busy=1 cnt=1",
                        bus_a.o_rd_busy1, bus_a.o_busy_cnt);
    end
    // Pulse reset between edges, with a reservation of r5 pending.
    @(negedge clk);
    bus_a.i_rsv_en = 1; bus_a.i_rsv_addr = 5;
    #1;
    rst_n = 0;
    #1;
    n_total++;
    if (bus_a.o_rd_data1 !== 32'h0) begin
      n_bad++; $display("FAIL reset_data: got %h expected 0", bus_a.o_rd_data1);
    end
    n_total++;
    if (bus_a.o_rd_busy1 !== 1'b0 || bus_a.o_busy_cnt !== 6'd0 || bus_a.o_rsv_stall !== 1'b0) begin
      n_bad++; $display("FAIL reset_busy: busy=%b cnt=%0d stall=%b expected 0 0 0",
                        bus_a.o_rd_busy1, bus_a.o_busy_cnt, bus_a.o_rsv_stall);
    end
    n_total++;
    if (bus_b.o_busy_cnt !== 6'd0 || bus_c.o_busy_cnt !== 4'd0) begin
      n_bad++; $display("FAIL reset_cnt_others: got %0d %0d expected 0 0",
                        bus_b.o_busy_cnt, bus_c.o_busy_cnt);
    end
    rst_n = 1;
    idle();
  endtask

  task automatic test_zero_reg();
    do_reset();
    @(negedge clk);
    bus_a.i_rd_addr1 = 0;
    bus_a.i_wr_en = 1; bus_a.i_wr_addr = 0; bus_a.i_wr_data = 32'h1234;
    bus_a.i_rsv_en = 1; bus_a.i_rsv_addr = 0;
    #1;
    n_total++;
    if (bus_a.o_rsv_stall !== 1'b0 || bus_a.o_rd_data1 !== 32'h0) begin
      n_bad++; $display("FAIL zero_same_cycle: stall=%b data=%h expected 0 0",
                        bus_a.o_rsv_stall, bus_a.o_rd_data1);
    end
    step();
    n_total++;
    if (bus_a.o_rd_data1 !== 32'h0 || bus_a.o_rd_busy1 !== 1'b0 || bus_a.o_busy_cnt !== 6'd0) begin
      n_bad++; $display("FAIL zero_after: data=%h busy=%b cnt=%0d expected 0 0 0",
                        bus_a.o_rd_data1, bus_a.o_rd_busy1, bus_a.o_busy_cnt);
    end
  endtask

  task automatic test_reserve_writeback();
    do_reset();
    @(negedge clk);
    bus_a.i_rd_addr1 = 3;
    bus_a.i_rsv_en = 1; bus_a.i_rsv_addr = 3;
    #1;
    n_total++;
    if (bus_a.o_rsv_stall !== 1'b0) begin
      n_bad++; $display("FAIL rsv_first_stall: got %b expected 0", bus_a.o_rsv_stall);
    end
    step();
    @(negedge clk);
    bus_a.i_rsv_en = 1; bus_a.i_rsv_addr = 3;
    #1;
    n_total++;
    if (bus_a.o_rsv_stall !== 1'b1) begin
      n_bad++; $display("FAIL rsv_second_stall: got %b expected 1", bus_a.o_rsv_stall);
    end
    step();
    n_total++;
    if (bus_a.o_busy_cnt !== 6'd1 || bus_a.o_rd_busy1 !== 1'b1) begin
      n_bad++; $display("FAIL rsv_held: cnt=%0d busy=%b expected 1 1",
                        bus_a.o_busy_cnt, bus_a.o_rd_busy1);
    end
    @(negedge clk);
    bus_a.i_wr_en = 1; bus_a.i_wr_addr = 3; bus_a.i_wr_data = 32'hA5A5A5A5;
    bus_a.i_rsv_en = 1; bus_a.i_rsv_addr = 3;
    #1;
    n_total++;
    if (bus_a.o_rsv_stall !== 1'b0) begin
      n_bad++; $display("FAIL wb_rsv_stall: got %b expected 0", bus_a.o_rsv_stall);
    end
    step();
    n_total++;
    if (bus_a.o_rd_data1 !== 32'hA5A5A5A5 || bus_a.o_rd_busy1 !== 1'b1 || bus_a.o_busy_cnt !== 6'd1) begin
      n_bad++; $display("FAIL wb_rsv_after: data=%h busy=%b cnt=%0d expected a5a5a5a5 1 1",
                        bus_a.o_rd_data1, bus_a.o_rd_busy1, bus_a.o_busy_cnt);
    end
  endtask

  task automatic test_bypass();
    do_reset();
    @(negedge clk);
    bus_a.i_wr_en = 1; bus_a.i_wr_addr = 7; bus_a.i_wr_data = 32'h11;
    bus_a.i_rsv_en = 1; bus_a.i_rsv_addr = 7;
    bus_b.i_wr_en = 1; bus_b.i_wr_addr = 7; bus_b.i_wr_data = 32'h11;
    bus_b.i_rsv_en = 1; bus_b.i_rsv_addr = 7;
    step();
    @(negedge clk);
    bus_a.i_rd_addr2 = 7; bus_b.i_rd_addr2 = 7;
    bus_a.i_wr_en = 1; bus_a.i_wr_addr = 7; bus_a.i_wr_data = 32'h55;
    bus_b.i_wr_en = 1; bus_b.i_wr_addr = 7; bus_b.i_wr_data = 32'h55;
    #1;
    n_total++;
    if (bus_a.o_rd_data2 !== 32'h55 || bus_a.o_rd_busy2 !== 1'b0) begin
      n_bad++; $display("FAIL bypass_on: data=%h busy=%b expected 55 0",
                        bus_a.o_rd_data2, bus_a.o_rd_busy2);
    end
    n_total++;
    if (bus_b.o_rd_data2 !== 32'h11 || bus_b.o_rd_busy2 !== 1'b1) begin
      n_bad++; $display("FAIL bypass_off: data=%h busy=%b expected 11 1",
                        bus_b.o_rd_data2, bus_b.o_rd_busy2);
    end
    step();
    n_total++;
    if (bus_b.o_rd_data2 !== 32'h55 || bus_b.o_rd_busy2 !== 1'b0 || bus_b.o_busy_cnt !== 6'd0) begin
      n_bad++; $display("FAIL bypass_off_after: data=%h busy=%b cnt=%0d expected 55 0 0",
                        bus_b.o_rd_data2, bus_b.o_rd_busy2, bus_b.o_busy_cnt);
    end
  endtask

  task automatic test_counter();
    int regs [3] = '{1, 2, 4};
    do_reset();
    foreach (regs[k]) begin
      @(negedge clk);
      bus_a.i_rsv_en = 1; bus_a.i_rsv_addr = 5'(regs[k]);
      step();
    end
    n_total++;
    if (bus_a.o_busy_cnt !== 6'd3) begin
      n_bad++; $display("FAIL cnt_three: got %0d expected 3", bus_a.o_busy_cnt);
    end
    @(negedge clk);
    bus_a.i_wr_en = 1; bus_a.i_wr_addr = 2; bus_a.i_wr_data = 32'h22;
    bus_a.i_rsv_en = 1; bus_a.i_rsv_addr = 6;
    step();
    bus_a.i_rd_addr1 = 2; bus_a.i_rd_addr2 = 6;
    #1;
    n_total++;
    if (bus_a.o_busy_cnt !== 6'd3 || bus_a.o_rd_busy1 !== 1'b0 || bus_a.o_rd_busy2 !== 1'b1) begin
      n_bad++; $display("FAIL cnt_swap: cnt=%0d b2=%b b6=%b expected 3 0 1",
                        bus_a.o_busy_cnt, bus_a.o_rd_busy1, bus_a.o_rd_busy2);
    end
    // Write to a register that is not busy: data updates, count unchanged.
    @(negedge clk);
    bus_a.i_wr_en = 1; bus_a.i_wr_addr = 10; bus_a.i_wr_data = 32'h0BADF00D;
    step();
    bus_a.i_rd_addr1 = 10;
    #1;
    n_total++;
    if (bus_a.o_rd_data1 !== 32'h0BADF00D || bus_a.o_busy_cnt !== 6'd3) begin
      n_bad++; $display("FAIL cnt_free_write: data=%h cnt=%0d expected 0badf00d 3",
                        bus_a.o_rd_data1, bus_a.o_busy_cnt);
    end
    @(negedge clk);
    bus_a.i_rd_addr1 = 9; bus_a.i_rd_addr2 = 1;
    bus_a.i_flush = 1; bus_a.i_rsv_en = 1; bus_a.i_rsv_addr = 9;
    #1;
    n_total++;
    if (bus_a.o_rsv_stall !== 1'b0) begin
      n_bad++; $display("FAIL flush_stall: got %b expected 0", bus_a.o_rsv_stall);
    end
    step();
    n_total++;
    if (bus_a.o_busy_cnt !== 6'd0 || bus_a.o_rd_busy1 !== 1'b0 || bus_a.o_rd_busy2 !== 1'b0) begin
      n_bad++; $display("FAIL flush_after: cnt=%0d b9=%b b1=%b expected 0 0 0",
                        bus_a.o_busy_cnt, bus_a.o_rd_busy1, bus_a.o_rd_busy2);
    end
  endtask

  task automatic test_param();
    do_reset();
    @(negedge clk);
    bus_c.i_rd_addr1 = 0;
    bus_c.i_wr_en = 1; bus_c.i_wr_addr = 0; bus_c.i_wr_data = 16'hBEEF;
    step();
    n_total++;
    if (bus_c.o_rd_data1 !== 16'hBEEF) begin
      n_bad++; $display("FAIL param_r0: got %h expected beef", bus_c.o_rd_data1);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      bus_c.i_rsv_en = 1; bus_c.i_rsv_addr = 3'(k);
      step();
    end
    n_total++;
    if (bus_c.o_busy_cnt !== 4'd8 || bus_c.o_rd_busy1 !== 1'b1) begin
      n_bad++; $display("FAIL param_all_busy: cnt=%0d b0=%b expected 8 1",
                        bus_c.o_busy_cnt, bus_c.o_rd_busy1);
    end
    @(negedge clk);
    bus_c.i_rsv_en = 1; bus_c.i_rsv_addr = 0;
    #1;
    n_total++;
    if (bus_c.o_rsv_stall !== 1'b1) begin
      n_bad++; $display("FAIL param_r0_stall: got %b expected 1", bus_c.o_rsv_stall);
    end
    step();
    @(negedge clk);
    bus_c.i_wr_en = 1; bus_c.i_wr_addr = 5; bus_c.i_wr_data = 16'h0505;
    step();
    n_total++;
    if (bus_c.o_busy_cnt !== 4'd7) begin
      n_bad++; $display("FAIL param_release: got %0d expected 7", bus_c.o_busy_cnt);
    end
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_n   = 0;
    bus_a.i_wr_addr = 0; bus_a.i_wr_data = 0; bus_a.i_rsv_addr = 0;
    bus_a.i_rd_addr1 = 0; bus_a.i_rd_addr2 = 0;
    bus_b.i_wr_addr = 0; bus_b.i_wr_data = 0; bus_b.i_rsv_addr = 0;
    bus_b.i_rd_addr1 = 0; bus_b.i_rd_addr2 = 0;
    bus_c.i_wr_addr = 0; bus_c.i_wr_data = 0; bus_c.i_rsv_addr = 0;
    bus_c.i_rd_addr1 = 0; bus_c.i_rd_addr2 = 0;
    idle();
    #12;
    rst_n = 1;
    test_reset();
    test_zero_reg();
    test_reserve_writeback();
    test_bypass();
    test_counter();
    test_param();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
